// File: rtl/ntt_sequencer_if.sv
// Host stream, processor control pins and result framing for one ntt_sequencer.
// The slave modport is the sequencer side; the master modport is the host/processor side.
interface ntt_sequencer_if #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_N          = 12
);
    // A host word transfers on every rising clk edge where in_valid and in_ready are both 1;
    // in_data must stay stable while in_valid is high and in_ready is low.
    logic                               in_valid;
    logic                               in_ready;
    logic [59:0]                        in_data;
    logic                               proc_write_enable;
    logic [LOG_N-2:0]                   proc_address_in;
    logic [59:0]                        proc_data_in;
    logic                               proc_start;
    logic                               proc_output_active;
    logic                               out_valid;
    logic [LOG_N-3-LOG_CORE_COUNT:0]    out_beat;
    logic                               out_last;
    logic                               busy;
    logic                               done;
    logic                               error;

    modport slave (
        input  in_valid, in_data, proc_output_active,
        output in_ready, proc_write_enable, proc_address_in, proc_data_in, proc_start,
        output out_valid, out_beat, out_last, busy, done, error
    );

    modport master (
        output in_valid, in_data, proc_output_active,
        input  in_ready, proc_write_enable, proc_address_in, proc_data_in, proc_start,
        input  out_valid, out_beat, out_last, busy, done, error
    );
endinterface

// File: rtl/ntt_sequencer.sv
// Load / start / drain control front-end for one NTT processor instance.
// Define NTT_SEQ_TIMEOUT_EN to add a compute-phase watchdog (limit TIMEOUT_CYCLES).
module ntt_sequencer #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_N          = 12,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic           clk,
    input  logic           rst,
    ntt_sequencer_if.slave bus,
    output logic [2:0]     dbg_state
);
    localparam int AW = LOG_N - 1;
    localparam int BW = LOG_N - 2 - LOG_CORE_COUNT;
    localparam int DW = 60;
    localparam int SW = $clog2(SETTLE_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_START   = 3'd3,
        S_COMPUTE = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   word_cnt_q, word_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            error_q, error_d;
    logic            act_q, act_d;

    logic ready_c, accept, rise, frame;
    logic out_valid_c, out_last_c, start_c, done_c;

`ifdef NTT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            settle_q   <= '0;
            beat_q     <= '0;
            error_q    <= 1'b0;
            act_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            settle_q   <= settle_d;
            beat_q     <= beat_d;
            error_q    <= error_d;
            act_q      <= act_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        settle_d   = settle_q;
        beat_d     = beat_q;
        error_d    = error_q;
        act_d      = bus.proc_output_active;
        start_c    = 1'b0;
        done_c     = 1'b0;
`ifdef NTT_SEQ_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        // The processor has no reset, so a still-running instance blocks a new load.
        ready_c     = (state_q == S_LOAD) || ((state_q == S_IDLE) && !bus.proc_output_active);
        accept      = ready_c & bus.in_valid;
        rise        = bus.proc_output_active & ~act_q;
        // The rising-edge cycle already carries result beat 0.
        frame       = (state_q == S_DRAIN) || ((state_q == S_COMPUTE) && rise);
        out_valid_c = frame & bus.proc_output_active;
        out_last_c  = out_valid_c & (beat_q == '1);

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    addr_d  = word_cnt_q;
                    data_d  = bus.in_data;
                    if (word_cnt_q == '1) begin
                        word_cnt_d = '0;
                        settle_d   = '0;
                        state_d    = S_SETTLE;
                    end else begin
                        word_cnt_d = word_cnt_q + AW'(1);
                        state_d    = S_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                // First SETTLE cycle still shows the last write; SETTLE_CYCLES quiet cycles follow.
                if (settle_q == SW'(SETTLE_CYCLES)) begin
                    settle_d = '0;
                    state_d  = S_START;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_START: begin
                start_c = 1'b1;
                beat_d  = '0;
                state_d = S_COMPUTE;
`ifdef NTT_SEQ_TIMEOUT_EN
                to_cnt_d = TW'(1);
`endif
            end
            S_COMPUTE: begin
`ifdef NTT_SEQ_TIMEOUT_EN
                if (!rise) begin
                    if (to_cnt_q + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
`endif
            end
            S_DRAIN: ;
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: ;
            default: state_d = S_IDLE;
        endcase

        if (frame) begin
            if (out_valid_c) begin
                if (out_last_c) begin
                    beat_d  = '0;
                    state_d = S_DONE;
                end else begin
                    beat_d  = beat_q + BW'(1);
                    state_d = S_DRAIN;
                end
            end else begin
                error_d = 1'b1;
                state_d = S_ERROR;
            end
        end
    end

    // in_ready is combinational, so it is also held low while reset is asserted.
    assign bus.in_ready          = ready_c & ~rst;
    assign bus.proc_write_enable = wr_en_q;
    assign bus.proc_address_in   = addr_q;
    assign bus.proc_data_in      = data_q;
    assign bus.proc_start        = start_c;
    assign bus.out_valid         = out_valid_c;
    assign bus.out_beat          = out_valid_c ? beat_q : '0;
    assign bus.out_last          = out_last_c;
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.done              = done_c;
    assign bus.error             = error_q;
    assign dbg_state             = state_q;
endmodule
